vga_ctrl: RTL and testbench
===========================

VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 Parameter H_SYNC, default 96, hsync pulse width in pixel clocks.
REQ-002 Parameter H_BACK, default 48, horizontal back porch.
REQ-003 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-004 Parameter H_FRONT, default 16, horizontal front porch; H_TOTAL = sum of the four = 800.
REQ-005 Parameters V_SYNC 2, V_BACK 33, V_ACTIVE 480, V_FRONT 10, in lines; V_TOTAL = 525.
REQ-006 Parameter LEAD, default 1, legal 0..4, pixel-source read latency in clocks.
REQ-007 vga_clk  input  1  pixel clock; single clock domain.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 rgb_in  input  24  pixel data from the image source, valid LEAD clocks after its address.
REQ-010 addr_h  output  12  requested column, 1..H_ACTIVE inside the request window, 0 outside.
REQ-011 addr_v  output  12  requested row, 1..V_ACTIVE on active lines, 0 otherwise.
REQ-012 vga_hs  output  1  horizontal sync, active low.
REQ-013 vga_vs  output  1  vertical sync, active low.
REQ-014 vga_de  output  1  display enable, high for visible pixels.
REQ-015 rgb_out  output  24  pixel to DAC, 0 when vga_de low.
REQ-016 frame_start  output  1  one-clock pulse at the first clock of each frame.

Function
REQ-017 h_cnt SHALL count 0..H_TOTAL-1 every clock and wrap to 0.
REQ-018 v_cnt SHALL increment when h_cnt wraps, count 0..V_TOTAL-1, and wrap to 0 when both counters wrap together.
REQ-019 The raw timing signals SHALL be combinational from the counters:
  - hs_raw = (h_cnt < H_SYNC).
  - vs_raw = (v_cnt < V_SYNC).
  - v_act = v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1].
  - de_raw = v_act AND h_cnt in [HS0, HS0+H_ACTIVE-1], where HS0 = H_SYNC+H_BACK.
REQ-020 The request window SHALL be v_act AND h_cnt in [HS0-LEAD, HS0+H_ACTIVE-1-LEAD].
REQ-021 addr_h SHALL equal h_cnt-(HS0-LEAD)+1 inside the request window and 0 outside; addr_h is combinational from the counter.
REQ-022 addr_v SHALL equal v_cnt-(V_SYNC+V_BACK)+1 while v_act and 0 otherwise; addr_v is combinational from the counter.
REQ-023 Address 1 SHALL lead the first de_raw clock of a line by exactly LEAD clocks; consecutive clocks SHALL issue consecutive addresses with no gaps.
REQ-024 Registered outputs SHALL update each clock as follows (one clock latency from the counters):
  - vga_hs <= NOT hs_raw.
  - vga_vs <= NOT vs_raw.
  - vga_de <= de_raw.
  - rgb_out <= de_raw ? rgb_in : 0.
  - frame_start <= (h_cnt==0 AND v_cnt==0).
REQ-025 With the default parameters, each line SHALL have exactly 640 vga_de clocks and each frame exactly 480 lines with vga_de, i.e. 307200 visible pixels per frame.
REQ-026 Counter width SHALL be 12 bits; all comparisons SHALL be unsigned, with no truncation for parameter totals up to 4095.
REQ-027 With LEAD=0, the request window SHALL equal the de_raw window.

Reset
REQ-028 While rst is high at a vga_clk edge, the block SHALL load h_cnt=0, v_cnt=0, vga_hs=1, vga_vs=1, vga_de=0, rgb_out=0 and frame_start=0.
REQ-029 On the first edge after rst falls, the block SHALL register the timing for h_cnt=0, v_cnt=0 (frame_start=1, vga_hs=0, vga_vs=0), then proceed normally.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no partial-line recovery; the next frame SHALL start from counter 0.
REQ-031 addr_h and addr_v SHALL read 0 during reset, since the counters are 0.

Structure
REQ-032 The timing defaults, H_TOTAL/V_TOTAL and the 12-bit coordinate width SHALL live in the shared package vga_timing_pkg.
REQ-033 The block SHALL contain no sub-module; the counters, window decode and output register are flat.

Verification
REQ-034 Release rst, run one line at defaults -> vga_hs low for clocks 0..95 of the line, vga_de high for exactly 640 consecutive clocks starting at registered count 144.
REQ-035 Run a full frame -> vga_vs low for lines 0..1; first vga_de on line 35, last on line 514; frame_start pulses once per 420000 clocks.
REQ-036 LEAD=1, rgb_in driven as a function of the previous clock's {addr_v,addr_h} -> rgb_out on the first visible pixel equals the value for (1,1), on the last visible pixel the value for (480,640); 0 elsewhere.
REQ-037 Check addresses on an active line -> addr_h goes 1..640 over clocks 143..782, is 0 at clocks 142 and 783, and addr_v is 1 throughout line 35.
REQ-038 Assert rst for 3 clocks at line 200, clock 400 -> outputs return to reset values, next frame_start arrives 1 clock after release, and the pixel count of the following frame is 307200.
REQ-039 LEAD=0 and LEAD=4 -> the addr_h=1 clock precedes the first vga_de by LEAD+1 clocks at the outputs; no address is missed or duplicated.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and coordinate widths for the 640x480@60 raster.
package vga_timing_pkg;

   localparam int unsigned CW    = 12;
   localparam int unsigned RGB_W = 24;

   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BACK_DEF   = 48;
   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FRONT_DEF  = 16;
   localparam int unsigned H_TOTAL      = H_SYNC_DEF + H_BACK_DEF + H_ACTIVE_DEF + H_FRONT_DEF;

   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BACK_DEF   = 33;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FRONT_DEF  = 10;
   localparam int unsigned V_TOTAL      = V_SYNC_DEF + V_BACK_DEF + V_ACTIVE_DEF + V_FRONT_DEF;

   localparam int unsigned LEAD_DEF = 1;

endpackage

// File: rtl/vga_ctrl.sv
// VGA raster timing generator: counters, window decode, pixel request addresses
// that run LEAD clocks ahead of display, and a registered output stage.
module vga_ctrl
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BACK   = H_BACK_DEF,
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FRONT  = H_FRONT_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BACK   = V_BACK_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FRONT  = V_FRONT_DEF,
   parameter int unsigned LEAD     = LEAD_DEF
) (
   input  logic              vga_clk,
   input  logic              rst,
   input  logic [RGB_W-1:0]  rgb_in,
   output logic [CW-1:0]     addr_h,
   output logic [CW-1:0]     addr_v,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_de,
   output logic [RGB_W-1:0]  rgb_out,
   output logic              frame_start
);

   localparam int unsigned HT    = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int unsigned VT    = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int unsigned HS0   = H_SYNC + H_BACK;
   localparam int unsigned HE    = HS0 + H_ACTIVE - 1;
   localparam int unsigned VS0   = V_SYNC + V_BACK;
   localparam int unsigned VE    = VS0 + V_ACTIVE - 1;
   localparam int unsigned RQ_LO = HS0 - LEAD;
   localparam int unsigned RQ_HI = HE - LEAD;

   logic [CW-1:0] h_cnt;
   logic [CW-1:0] v_cnt;
   logic          hs_raw;
   logic          vs_raw;
   logic          v_act;
   logic          de_raw;
   logic          req_win;

   // Pixel and line counters; the frame wraps when both roll over together.
   always_ff @(posedge vga_clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == CW'(HT - 1)) begin
         h_cnt <= '0;
         if (v_cnt == CW'(VT - 1)) begin
            v_cnt <= '0;
         end else begin
            v_cnt <= v_cnt + CW'(1);
         end
      end else begin
         h_cnt <= h_cnt + CW'(1);
      end
   end

   assign hs_raw  = (h_cnt < CW'(H_SYNC));
   assign vs_raw  = (v_cnt < CW'(V_SYNC));
   assign v_act   = (v_cnt >= CW'(VS0)) && (v_cnt <= CW'(VE));
   assign de_raw  = v_act && (h_cnt >= CW'(HS0)) && (h_cnt <= CW'(HE));
   assign req_win = v_act && (h_cnt >= CW'(RQ_LO)) && (h_cnt <= CW'(RQ_HI));

   // Addresses are 1-based and lead the display window by the source latency.
   assign addr_h = req_win ? (h_cnt - CW'(RQ_LO) + CW'(1)) : '0;
   assign addr_v = v_act   ? (v_cnt - CW'(VS0)   + CW'(1)) : '0;

   always_ff @(posedge vga_clk) begin
      if (rst) begin
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_de      <= 1'b0;
         rgb_out     <= '0;
         frame_start <= 1'b0;
      end else begin
         vga_hs      <= ~hs_raw;
         vga_vs      <= ~vs_raw;
         vga_de      <= de_raw;
         rgb_out     <= de_raw ? rgb_in : '0;
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end
   end

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: one default-timing instance plus three shrunken rasters
// with LEAD 1/0/4, all checked against a position-based raster model.
module tb_vga_ctrl;
   import vga_timing_pkg::*;

   typedef struct {
      int hs; int hb; int ha; int hf;
      int vs; int vb; int va; int vf;
      int ld;
   } cfg_t;

   localparam int NI = 4;

   logic        clk;
   logic        rst;
   logic [23:0] rgb_i [NI];
   logic [11:0] ah    [NI];
   logic [11:0] av    [NI];
   logic        hs_o  [NI];
   logic        vs_o  [NI];
   logic        de_o  [NI];
   logic        fs_o  [NI];
   logic [23:0] rgb_o [NI];

   int          checks;
   int          errors;
   int          k;
   logic [23:0] salt;
   cfg_t        cfg  [NI];
   logic [23:0] hist [NI][5];

   vga_ctrl #(.LEAD(1)) u_d (
      .vga_clk(clk), .rst(rst), .rgb_in(rgb_i[0]), .addr_h(ah[0]), .addr_v(av[0]),
      .vga_hs(hs_o[0]), .vga_vs(vs_o[0]), .vga_de(de_o[0]), .rgb_out(rgb_o[0]),
      .frame_start(fs_o[0]));

   vga_ctrl #(.H_SYNC(4), .H_BACK(3), .H_ACTIVE(10), .H_FRONT(2), .V_SYNC(2), .V_BACK(3),
              .V_ACTIVE(6), .V_FRONT(2), .LEAD(1)) u_s1 (
      .vga_clk(clk), .rst(rst), .rgb_in(rgb_i[1]), .addr_h(ah[1]), .addr_v(av[1]),
      .vga_hs(hs_o[1]), .vga_vs(vs_o[1]), .vga_de(de_o[1]), .rgb_out(rgb_o[1]),
      .frame_start(fs_o[1]));

   vga_ctrl #(.H_SYNC(4), .H_BACK(3), .H_ACTIVE(10), .H_FRONT(2), .V_SYNC(2), .V_BACK(3),
              .V_ACTIVE(6), .V_FRONT(2), .LEAD(0)) u_s0 (
      .vga_clk(clk), .rst(rst), .rgb_in(rgb_i[2]), .addr_h(ah[2]), .addr_v(av[2]),
      .vga_hs(hs_o[2]), .vga_vs(vs_o[2]), .vga_de(de_o[2]), .rgb_out(rgb_o[2]),
      .frame_start(fs_o[2]));

   vga_ctrl #(.H_SYNC(4), .H_BACK(3), .H_ACTIVE(10), .H_FRONT(2), .V_SYNC(2), .V_BACK(3),
              .V_ACTIVE(6), .V_FRONT(2), .LEAD(4)) u_s4 (
      .vga_clk(clk), .rst(rst), .rgb_in(rgb_i[3]), .addr_h(ah[3]), .addr_v(av[3]),
      .vga_hs(hs_o[3]), .vga_vs(vs_o[3]), .vga_de(de_o[3]), .rgb_out(rgb_o[3]),
      .frame_start(fs_o[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Image source: returns the pixel for the address seen ld clocks ago; idle reads are noise.
   always @(posedge clk) begin
      logic [23:0] a;
      #1;
      for (int i = 0; i < NI; i++) begin
         for (int j = 4; j > 0; j--) hist[i][j] = hist[i][j-1];
         hist[i][0] = {av[i], ah[i]};
         a = hist[i][cfg[i].ld];
         rgb_i[i] = ($isunknown(a) || a == 24'h0) ? 24'($urandom) : (a ^ salt);
      end
   end

   function automatic int tot(cfg_t c);
      return (c.hs + c.hb + c.ha + c.hf) * (c.vs + c.vb + c.va + c.vf);
   endfunction

   // Expected {hs,vs,de,fs,rgb} after kk post-reset edges (outputs show position kk-1).
   function automatic logic [27:0] exp_out(cfg_t c, int kk, logic [23:0] s);
      int ht, p, ln, col, r0, c0;
      logic de;
      if (kk == 0) return {4'b1100, 24'h0};
      ht  = c.hs + c.hb + c.ha + c.hf;
      p   = (kk - 1) % tot(c);
      ln  = p / ht;
      col = p % ht;
      r0  = c.vs + c.vb;
      c0  = c.hs + c.hb;
      de  = (ln >= r0) && (ln < r0 + c.va) && (col >= c0) && (col < c0 + c.ha);
      return {col >= c.hs, ln >= c.vs, de, p == 0,
              de ? ({12'(ln - r0 + 1), 12'(col - c0 + 1)} ^ s) : 24'h0};
   endfunction

   // Expected {addr_v,addr_h}: the visible pixel that will be displayed ld clocks from now.
   function automatic logic [23:0] exp_addr(cfg_t c, int kk);
      int ht, q, ln, col, r0, c0, f, v, h;
      ht  = c.hs + c.hb + c.ha + c.hf;
      q   = kk % tot(c);
      ln  = q / ht;
      col = q % ht;
      r0  = c.vs + c.vb;
      c0  = c.hs + c.hb;
      if (ln < r0 || ln >= r0 + c.va) return 24'h0;
      v = ln - r0 + 1;
      f = col + c.ld;
      h = (f >= c0 && f < c0 + c.ha) ? f - c0 + 1 : 0;
      return {12'(v), 12'(h)};
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst) k = 0;
      else k = k + 1;
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) begin
         tick();
         for (int i = 0; i < NI; i++) begin
            checks++;
            if ({hs_o[i], vs_o[i], de_o[i], fs_o[i], rgb_o[i]} !== {4'b1100, 24'h0}) begin
               errors++;
               $display("FAIL reset_out inst%0d got=%b_%b_%b_%b_%h exp=1_1_0_0_000000",
                        i, hs_o[i], vs_o[i], de_o[i], fs_o[i], rgb_o[i]);
            end
            checks++;
            if ({av[i], ah[i]} !== 24'h0) begin
               errors++;
               $display("FAIL reset_addr inst%0d got=%h exp=000000", i, {av[i], ah[i]});
            end
         end
      end
   endtask

   task automatic test_first_edge();
      rst = 1'b0;
      tick();
      for (int i = 0; i < NI; i++) begin
         checks++;
         if ({hs_o[i], vs_o[i], de_o[i], fs_o[i], rgb_o[i]} !== {4'b0001, 24'h0}) begin
            errors++;
            $display("FAIL first_edge inst%0d got=%b_%b_%b_%b_%h exp=0_0_0_1_000000",
                     i, hs_o[i], vs_o[i], de_o[i], fs_o[i], rgb_o[i]);
         end
      end
   endtask

   task automatic test_addresses();
      int first_c, last_c, n_nz;
      logic [23:0] e;
      first_c = -1; last_c = -1; n_nz = 0;
      while (k < 36 * 800) begin
         tick();
         for (int i = 0; i < NI; i++) begin
            e = exp_addr(cfg[i], k);
            checks++;
            if ({av[i], ah[i]} !== e) begin
               errors++;
               $display("FAIL addr inst%0d k=%0d got=%h exp=%h", i, k, {av[i], ah[i]}, e);
            end
         end
         if (k / 800 == 35) begin
            if (ah[0] != 12'd0) begin
               if (first_c < 0) first_c = k % 800;
               last_c = k % 800;
               n_nz++;
            end
            checks++;
            if (av[0] !== 12'd1) begin
               errors++;
               $display("FAIL line35_addr_v col=%0d got=%0d exp=1", k % 800, av[0]);
            end
         end
      end
      checks++;
      if (first_c != 143 || last_c != 782 || n_nz != 640) begin
         errors++;
         $display("FAIL addr_h_window got first=%0d last=%0d n=%0d exp first=143 last=782 n=640",
                  first_c, last_c, n_nz);
      end
   endtask

   task automatic test_line_timing();
      int n_hs, hs_last, n_de, de_first, rises, col;
      logic prev_de;
      logic [27:0] e;
      n_hs = 0; hs_last = -1; n_de = 0; de_first = -1; rises = 0; prev_de = 1'b0;
      repeat (800) begin
         tick();
         col = (k - 1) % 800;
         e = exp_out(cfg[0], k, salt);
         checks++;
         if ({hs_o[0], vs_o[0], de_o[0], fs_o[0], rgb_o[0]} !== e) begin
            errors++;
            $display("FAIL line_out col=%0d got=%h exp=%h", col,
                     {hs_o[0], vs_o[0], de_o[0], fs_o[0], rgb_o[0]}, e);
         end
         if (hs_o[0] === 1'b0) begin n_hs++; hs_last = col; end
         if (de_o[0] === 1'b1) begin
            if (n_de == 0) de_first = col;
            n_de++;
            if (!prev_de) rises++;
         end
         prev_de = (de_o[0] === 1'b1);
      end
      checks++;
      if (n_hs != 96 || hs_last != 95) begin
         errors++;
         $display("FAIL hsync_width got n=%0d last=%0d exp n=96 last=95", n_hs, hs_last);
      end
      checks++;
      if (n_de != 640 || de_first != 144 || rises != 1) begin
         errors++;
         $display("FAIL de_run got n=%0d first=%0d runs=%0d exp n=640 first=144 runs=1",
                  n_de, de_first, rises);
      end
   endtask

   task automatic test_frame();
      int n_fs [NI];
      int n_de [NI];
      int last_fs [NI];
      logic [27:0] e;
      logic [23:0] ea;
      for (int i = 1; i < NI; i++) begin n_fs[i] = 0; n_de[i] = 0; last_fs[i] = -1; end
      repeat (2 * 247) begin
         tick();
         for (int i = 1; i < NI; i++) begin
            e  = exp_out(cfg[i], k, salt);
            ea = exp_addr(cfg[i], k);
            checks++;
            if ({hs_o[i], vs_o[i], de_o[i], fs_o[i], rgb_o[i]} !== e) begin
               errors++;
               $display("FAIL frame_out inst%0d k=%0d got=%h exp=%h", i, k,
                        {hs_o[i], vs_o[i], de_o[i], fs_o[i], rgb_o[i]}, e);
            end
            checks++;
            if ({av[i], ah[i]} !== ea) begin
               errors++;
               $display("FAIL frame_addr inst%0d k=%0d got=%h exp=%h", i, k, {av[i], ah[i]}, ea);
            end
            if (de_o[i] === 1'b1) n_de[i]++;
            if (fs_o[i] === 1'b1) begin
               if (last_fs[i] >= 0) begin
                  checks++;
                  if (k - last_fs[i] != 247) begin
                     errors++;
                     $display("FAIL fs_period inst%0d got=%0d exp=247", i, k - last_fs[i]);
                  end
               end
               last_fs[i] = k;
               n_fs[i]++;
            end
         end
      end
      for (int i = 1; i < NI; i++) begin
         checks++;
         if (n_fs[i] != 2 || n_de[i] != 120) begin
            errors++;
            $display("FAIL frame_counts inst%0d got fs=%0d px=%0d exp fs=2 px=120",
                     i, n_fs[i], n_de[i]);
         end
      end
   endtask

   task automatic test_lead();
      int a1_t [NI];
      int nr [NI];
      logic [11:0] pa [NI];
      logic pde [NI];
      for (int i = 1; i < NI; i++) begin a1_t[i] = -1; nr[i] = 0; pa[i] = '0; pde[i] = 1'b1; end
      repeat (2 * 247) begin
         tick();
         for (int i = 1; i < NI; i++) begin
            if (ah[i] == 12'd1) a1_t[i] = k;
            if (ah[i] != 12'd0) begin
               checks++;
               if (ah[i] !== ((pa[i] == 12'd0) ? 12'd1 : pa[i] + 12'd1)) begin
                  errors++;
                  $display("FAIL addr_seq inst%0d got=%0d prev=%0d", i, ah[i], pa[i]);
               end
            end else if (pa[i] != 12'd0) begin
               checks++;
               if (pa[i] !== 12'd10) begin
                  errors++;
                  $display("FAIL addr_last inst%0d got=%0d exp=10", i, pa[i]);
               end
            end
            if (de_o[i] === 1'b1 && !pde[i]) begin
               nr[i]++;
               if (a1_t[i] >= 0) begin
                  checks++;
                  if (k - a1_t[i] != cfg[i].ld + 1) begin
                     errors++;
                     $display("FAIL lead_gap inst%0d got=%0d exp=%0d", i, k - a1_t[i], cfg[i].ld + 1);
                  end
               end
            end
            pde[i] = (de_o[i] === 1'b1);
            pa[i]  = ah[i];
         end
      end
      for (int i = 1; i < NI; i++) begin
         checks++;
         if (nr[i] != 12) begin
            errors++;
            $display("FAIL lead_lines inst%0d got=%0d exp=12", i, nr[i]);
         end
      end
   endtask

   task automatic test_reset_midframe();
      int wait_n;
      int n_de [NI];
      logic [27:0] e;
      wait_n = int'($urandom_range(246, 0));
      repeat (wait_n) tick();
      rst  = 1'b1;
      salt = 24'($urandom);
      repeat (3) begin
         tick();
         for (int i = 0; i < NI; i++) begin
            checks++;
            if ({hs_o[i], vs_o[i], de_o[i], fs_o[i], rgb_o[i], av[i], ah[i]} !== {4'b1100, 48'h0}) begin
               errors++;
               $display("FAIL mid_reset inst%0d got=%b_%b_%b_%b_%h_%h exp=1_1_0_0_000000_000000",
                        i, hs_o[i], vs_o[i], de_o[i], fs_o[i], rgb_o[i], {av[i], ah[i]});
            end
         end
      end
      rst = 1'b0;
      tick();
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (fs_o[i] !== 1'b1) begin
            errors++;
            $display("FAIL restart_fs inst%0d got=%b exp=1", i, fs_o[i]);
         end
         n_de[i] = 0;
      end
      repeat (246) begin
         tick();
         for (int i = 1; i < NI; i++) begin
            e = exp_out(cfg[i], k, salt);
            checks++;
            if ({hs_o[i], vs_o[i], de_o[i], fs_o[i], rgb_o[i]} !== e) begin
               errors++;
               $display("FAIL restart_out inst%0d k=%0d got=%h exp=%h", i, k,
                        {hs_o[i], vs_o[i], de_o[i], fs_o[i], rgb_o[i]}, e);
            end
            if (de_o[i] === 1'b1) n_de[i]++;
         end
      end
      for (int i = 1; i < NI; i++) begin
         checks++;
         if (n_de[i] != 60) begin
            errors++;
            $display("FAIL restart_pixels inst%0d got=%0d exp=60", i, n_de[i]);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      k      = 0;
      rst    = 1'b1;
      salt   = 24'($urandom);
      cfg[0] = '{96, 48, 640, 16, 2, 33, 480, 10, 1};
      cfg[1] = '{4, 3, 10, 2, 2, 3, 6, 2, 1};
      cfg[2] = '{4, 3, 10, 2, 2, 3, 6, 2, 0};
      cfg[3] = '{4, 3, 10, 2, 2, 3, 6, 2, 4};
      test_reset();
      test_first_edge();
      test_addresses();
      test_line_timing();
      test_frame();
      test_lead();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
